// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for a non-forwarding 5-stage pipeline.
// A 3-entry scoreboard (EX/MEM/WB) holds the pending destination registers. A
// small FSM holds fetch while a control instruction is waiting for EX to resolve.
module hazard_ctrl #(
  parameter int WB_BYPASS = 0,
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_vld,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic [4:0]       i_id_rd,
  input  logic             i_id_regwen,
  input  logic             i_id_is_ctrl,
  input  logic             i_br_resolved,
  input  logic             i_br_taken,
  output logic             o_stall_if,
  output logic             o_stall_id,
  output logic             o_bubble_ex,
  output logic             o_flush_ifid,
  output logic             o_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int               TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  // A WB entry only matters when the register file cannot forward a same-cycle write.
  localparam logic WB_CHECK = (WB_BYPASS == 0);

  logic [0:0]       r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_err;
  logic             r_ex_vld, r_mem_vld, r_wb_vld;
  logic [4:0]       r_ex_rd, r_mem_rd, r_wb_rd;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_hit_rs1, w_hit_rs2;
  logic w_raw, w_issue, w_timeout;

  // Compare both decode sources against every pending destination.
  always_comb begin
    w_hit_rs1 = (r_ex_vld  && (r_ex_rd  == i_id_rs1)) ||
                (r_mem_vld && (r_mem_rd == i_id_rs1)) ||
                (WB_CHECK && r_wb_vld && (r_wb_rd == i_id_rs1));
    w_hit_rs2 = (r_ex_vld  && (r_ex_rd  == i_id_rs2)) ||
                (r_mem_vld && (r_mem_rd == i_id_rs2)) ||
                (WB_CHECK && r_wb_vld && (r_wb_rd == i_id_rs2));
  end

  // x0 is hardwired to zero, so reading it can never be a hazard.
  assign w_raw = i_id_vld &
                 ((i_id_use_rs1 & (|i_id_rs1) & w_hit_rs1) |
                  (i_id_use_rs2 & (|i_id_rs2) & w_hit_rs2));

  assign w_issue   = i_id_vld & ~w_raw & (r_state == S_RUN);
  assign w_timeout = (r_state == S_WAIT) & ~i_br_resolved & (r_timer == TMR_LAST);

  // Pipeline control outputs are decoded from the current state and inputs.
  always_comb begin
    o_stall_if   = 1'b0;
    o_stall_id   = 1'b0;
    o_bubble_ex  = 1'b0;
    o_flush_ifid = 1'b0;
    if (r_state == S_RUN) begin
      if (w_raw) begin
        o_stall_if  = 1'b1;
        o_stall_id  = 1'b1;
        o_bubble_ex = 1'b1;
      end
    end else begin
      // The decode instruction never issues while waiting; the resolve cycle
      // releases fetch and decode, and kills IF/ID when the redirect is taken.
      o_bubble_ex  = 1'b1;
      o_stall_if   = ~i_br_resolved;
      o_stall_id   = ~i_br_resolved;
      o_flush_ifid = i_br_resolved & i_br_taken;
    end
  end

  // Control FSM, wait timer and sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_timer <= '0;
      r_err   <= 1'b0;
    end else begin
      if (r_state == S_RUN) begin
        if (i_br_resolved) begin
          r_err <= 1'b1;
        end
        if (w_issue && i_id_is_ctrl) begin
          r_state <= S_WAIT;
          r_timer <= '0;
        end
      end else begin
        if (i_br_resolved) begin
          r_state <= S_RUN;
        end else if (w_timeout) begin
          r_err   <= 1'b1;
          r_state <= S_RUN;
        end else begin
          r_timer <= r_timer + TMR_W'(1);
        end
      end
    end
  end

  // Scoreboard shifts one stage per cycle; a bubble enters EX as an invalid entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ex_vld  <= 1'b0;
      r_mem_vld <= 1'b0;
      r_wb_vld  <= 1'b0;
      r_ex_rd   <= '0;
      r_mem_rd  <= '0;
      r_wb_rd   <= '0;
    end else begin
      r_ex_vld  <= w_issue & i_id_regwen & (|i_id_rd);
      r_ex_rd   <= i_id_rd;
      r_mem_vld <= r_ex_vld;
      r_mem_rd  <= r_ex_rd;
      r_wb_vld  <= r_mem_vld;
      r_wb_rd   <= r_mem_rd;
    end
  end

  // Performance counters, wrapping at their natural width.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (o_stall_id) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (o_flush_ifid) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign o_err       = r_err;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
